// File: rtl/vram_port_arbiter.sv
// ----------------------------------------------------------------------------
// vram_port_arbiter
//
// Shares the 32-bit CPU-side port of the dual-port VRAM between three
// requesters: the CPU bus, the DMA engine and a built-in fill engine that
// writes a constant word pattern over a range of VRAM words.
//
// Grant selection is combinational from the live requests and registered
// arbitration state, so an ack and the VRAM command appear in the same cycle.
// The VRAM captures the command on the next clock edge and returns read data
// one cycle later. That data is flagged by the requester's own rdvalid.
//
// Ports
//   clk, reset_n                       clock, asynchronous active-low reset
//   cpu_req/addr/wrdata/bytesel/wren   CPU request, held until cpu_ack
//   cpu_ack, cpu_rdvalid               CPU accept strobe, read-data-valid
//   dma_req/addr/wrdata/bytesel/wren   DMA request, held until dma_ack
//   dma_ack, dma_rdvalid               DMA accept strobe, read-data-valid
//   rddata                             shared read data (qualify with *_rdvalid)
//   fill_start/addr/len/data           fill launch pulse and its parameters
//   fill_busy, fill_done               fill running / one-cycle completion pulse
//   vram_addr/wrdata/bytesel/wren      command to VRAM port 1
//   vram_rddata                        VRAM port 1 read data (1-cycle latency)
// ----------------------------------------------------------------------------
module vram_port_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wrdata,
    input  logic [3:0]        cpu_bytesel,
    input  logic              cpu_wren,
    output logic              cpu_ack,
    output logic              cpu_rdvalid,
    input  logic              dma_req,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [31:0]       dma_wrdata,
    input  logic [3:0]        dma_bytesel,
    input  logic              dma_wren,
    output logic              dma_ack,
    output logic              dma_rdvalid,
    output logic [31:0]       rddata,
    input  logic              fill_start,
    input  logic [ADDR_W-1:0] fill_addr,
    input  logic [ADDR_W:0]   fill_len,
    input  logic [31:0]       fill_data,
    output logic              fill_busy,
    output logic              fill_done,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [31:0]       vram_wrdata,
    output logic [3:0]        vram_bytesel,
    output logic              vram_wren,
    input  logic [31:0]       vram_rddata
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0]     STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [SW-1:0]     STARVE_ONE = SW'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);
    localparam logic [ADDR_W:0]   REM_ONE    = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {
        FILL_IDLE = 2'd0,
        FILL_RUN  = 2'd1,
        FILL_DONE = 2'd2
    } fill_state_e;

    fill_state_e       fill_state_q;
    logic [ADDR_W-1:0] fill_addr_q;
    logic [ADDR_W:0]   fill_rem_q;
    logic [31:0]       fill_data_q;
    logic              fill_busy_q;
    logic              fill_done_q;

    logic              rr_q, rr_d;          // 0: DMA preferred, 1: fill preferred
    logic [SW-1:0]     starve_q, starve_d;  // saturating denied-cycle count
    logic              cpu_rdvalid_q;
    logic              dma_rdvalid_q;

    logic              fill_req_s;
    logic              other_pend_s;
    logic              starved_s;
    logic              gnt_cpu_s;
    logic              gnt_dma_s;
    logic              gnt_fill_s;

    // Grant selection: CPU first unless the DMA/fill side has starved; DMA vs fill by round-robin.
    always_comb begin
        fill_req_s   = (fill_state_q == FILL_RUN);
        other_pend_s = dma_req | fill_req_s;
        starved_s    = (starve_q >= STARVE_LIM);
        gnt_cpu_s    = 1'b0;
        gnt_dma_s    = 1'b0;
        gnt_fill_s   = 1'b0;
        if (!reset_n) begin
            // Nothing is granted while reset is held, keeping the VRAM port quiet.
            gnt_cpu_s = 1'b0;
        end else if (cpu_req && !(other_pend_s && starved_s)) begin
            gnt_cpu_s = 1'b1;
        end else if (dma_req && (!fill_req_s || !rr_q)) begin
            gnt_dma_s = 1'b1;
        end else if (fill_req_s) begin
            gnt_fill_s = 1'b1;
        end else begin
            gnt_cpu_s = 1'b0;
        end
    end

    // VRAM command mux: granted requester's fields, all zero when idle.
    always_comb begin
        vram_addr    = {ADDR_W{1'b0}};
        vram_wrdata  = 32'h0000_0000;
        vram_bytesel = 4'h0;
        vram_wren    = 1'b0;
        if (gnt_cpu_s) begin
            vram_addr    = cpu_addr;
            vram_wrdata  = cpu_wrdata;
            vram_bytesel = cpu_bytesel;
            vram_wren    = cpu_wren;
        end else if (gnt_dma_s) begin
            vram_addr    = dma_addr;
            vram_wrdata  = dma_wrdata;
            vram_bytesel = dma_bytesel;
            vram_wren    = dma_wren;
        end else if (gnt_fill_s) begin
            vram_addr    = fill_addr_q;
            vram_wrdata  = fill_data_q;
            vram_bytesel = 4'hF;
            vram_wren    = 1'b1;
        end else begin
            vram_wren    = 1'b0;
        end
    end

    // Next arbitration state: pointer flips on every DMA/fill grant, starvation count clears on one.
    always_comb begin
        rr_d     = rr_q ^ (gnt_dma_s | gnt_fill_s);
        starve_d = starve_q;
        if (gnt_dma_s || gnt_fill_s) begin
            starve_d = {SW{1'b0}};
        end else if (other_pend_s && !starved_s) begin
            starve_d = starve_q + STARVE_ONE;
        end else begin
            starve_d = starve_q;
        end
    end

    // Arbitration state and read-valid flags (data returns one cycle after a read ack).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_q          <= 1'b0;
            starve_q      <= {SW{1'b0}};
            cpu_rdvalid_q <= 1'b0;
            dma_rdvalid_q <= 1'b0;
        end else begin
            rr_q          <= rr_d;
            starve_q      <= starve_d;
            cpu_rdvalid_q <= gnt_cpu_s & ~cpu_wren;
            dma_rdvalid_q <= gnt_dma_s & ~dma_wren;
        end
    end

    // Fill sequencer: latch parameters, issue one full-word write per grant, pulse done.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fill_state_q <= FILL_IDLE;
            fill_addr_q  <= {ADDR_W{1'b0}};
            fill_rem_q   <= {(ADDR_W + 1){1'b0}};
            fill_data_q  <= 32'h0000_0000;
            fill_busy_q  <= 1'b0;
            fill_done_q  <= 1'b0;
        end else begin
            fill_done_q <= 1'b0;
            case (fill_state_q)
                FILL_IDLE: begin
                    if (fill_start) begin
                        fill_addr_q <= fill_addr;
                        fill_rem_q  <= fill_len;
                        fill_data_q <= fill_data;
                        if (fill_len == {(ADDR_W + 1){1'b0}}) begin
                            fill_state_q <= FILL_DONE;
                            fill_done_q  <= 1'b1;
                        end else begin
                            fill_state_q <= FILL_RUN;
                            fill_busy_q  <= 1'b1;
                        end
                    end else begin
                        fill_state_q <= FILL_IDLE;
                    end
                end
                FILL_RUN: begin
                    if (gnt_fill_s) begin
                        // Address wraps naturally at the top of VRAM.
                        fill_addr_q <= fill_addr_q + ADDR_ONE;
                        fill_rem_q  <= fill_rem_q - REM_ONE;
                        if (fill_rem_q == REM_ONE) begin
                            fill_state_q <= FILL_DONE;
                            fill_busy_q  <= 1'b0;
                            fill_done_q  <= 1'b1;
                        end else begin
                            fill_state_q <= FILL_RUN;
                        end
                    end else begin
                        fill_state_q <= FILL_RUN;
                    end
                end
                FILL_DONE: begin
                    fill_state_q <= FILL_IDLE;
                end
                default: begin
                    fill_state_q <= FILL_IDLE;
                    fill_busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_ack     = gnt_cpu_s;
    assign dma_ack     = gnt_dma_s;
    assign cpu_rdvalid = cpu_rdvalid_q;
    assign dma_rdvalid = dma_rdvalid_q;
    assign rddata      = vram_rddata;
    assign fill_busy   = fill_busy_q;
    assign fill_done   = fill_done_q;

endmodule

// File: tb/tb_vram_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_vram_port_arbiter
//
// Self-checking bench for vram_port_arbiter. A behavioural VRAM with one
// cycle of read latency is attached to the DUT. A reference model tracks the
// arbitration rules, the fill job and a shadow copy of memory, and it is
// compared against the DUT every cycle. Directed table vectors and
// hand-written sequences cover the specific corner cases. Randomized traffic
// follows.
// ----------------------------------------------------------------------------
module tb_vram_port_arbiter;

    localparam int ADDR_W     = 12;
    localparam int STARVE_MAX = 8;

    logic        clk;
    logic        reset_n;
    logic        cpu_req, cpu_wren, cpu_ack, cpu_rdvalid;
    logic [11:0] cpu_addr;
    logic [31:0] cpu_wrdata;
    logic [3:0]  cpu_bytesel;
    logic        dma_req, dma_wren, dma_ack, dma_rdvalid;
    logic [11:0] dma_addr;
    logic [31:0] dma_wrdata;
    logic [3:0]  dma_bytesel;
    logic [31:0] rddata;
    logic        fill_start, fill_busy, fill_done;
    logic [11:0] fill_addr;
    logic [12:0] fill_len;
    logic [31:0] fill_data;
    logic [11:0] vram_addr;
    logic [31:0] vram_wrdata;
    logic [3:0]  vram_bytesel;
    logic        vram_wren;
    logic [31:0] vram_rddata;

    vram_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wrdata(cpu_wrdata),
        .cpu_bytesel(cpu_bytesel), .cpu_wren(cpu_wren), .cpu_ack(cpu_ack),
        .cpu_rdvalid(cpu_rdvalid),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_wrdata(dma_wrdata),
        .dma_bytesel(dma_bytesel), .dma_wren(dma_wren), .dma_ack(dma_ack),
        .dma_rdvalid(dma_rdvalid),
        .rddata(rddata),
        .fill_start(fill_start), .fill_addr(fill_addr), .fill_len(fill_len),
        .fill_data(fill_data), .fill_busy(fill_busy), .fill_done(fill_done),
        .vram_addr(vram_addr), .vram_wrdata(vram_wrdata), .vram_bytesel(vram_bytesel),
        .vram_wren(vram_wren), .vram_rddata(vram_rddata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    // Behavioural VRAM port 1: byte-masked writes, registered read.
    logic [31:0] vram_mem [0:4095];
    always @(posedge clk) begin
        if (vram_wren) vram_mem[vram_addr] <= merge(vram_mem[vram_addr], vram_wrdata, vram_bytesel);
        vram_rddata <= vram_mem[vram_addr];
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [0:4095];
    int          m_rem;      // words still to write for the current fill job
    logic [11:0] m_faddr;
    logic [31:0] m_fdata;
    bit          m_done;     // fill_done expected this cycle
    bit          m_rr;       // 0: DMA goes next when both wait
    int          m_starve;   // cycles the DMA/fill side has been waiting
    int          m_owner;    // 0 none, 1 CPU, 2 DMA: whose read returns this cycle
    logic [31:0] m_rdata;
    int          m_win;      // 0 none, 1 CPU, 2 DMA, 3 fill

    task automatic model_reset();
        m_rem = 0; m_done = 1'b0; m_rr = 1'b0; m_starve = 0; m_owner = 0; m_win = 0;
    endtask

    function automatic int pick();
        bit other;
        other = dma_req || (m_rem > 0);
        if (cpu_req && !(other && m_starve >= STARVE_MAX)) return 1;
        if (dma_req && m_rem > 0) return m_rr ? 3 : 2;
        if (dma_req) return 2;
        if (m_rem > 0) return 3;
        return 0;
    endfunction

    // Settle to mid-cycle and compare every output with the model.
    task automatic half1();
        logic [11:0] ea; logic [31:0] ed; logic [3:0] eb; logic ew;
        #6;
        m_win = pick();
        ea = 12'h000; ed = 32'h0; eb = 4'h0; ew = 1'b0;
        if (m_win == 1) begin ea = cpu_addr; ed = cpu_wrdata; eb = cpu_bytesel; ew = cpu_wren; end
        if (m_win == 2) begin ea = dma_addr; ed = dma_wrdata; eb = dma_bytesel; ew = dma_wren; end
        if (m_win == 3) begin ea = m_faddr;  ed = m_fdata;    eb = 4'hF;        ew = 1'b1;     end
        check("m_cpu_ack", cpu_ack, m_win == 1);
        check("m_dma_ack", dma_ack, m_win == 2);
        check("m_vram_wren", vram_wren, ew);
        check("m_vram_addr", vram_addr, ea);
        check("m_vram_wrdata", vram_wrdata, ed);
        check("m_vram_bytesel", vram_bytesel, eb);
        check("m_cpu_rdvalid", cpu_rdvalid, m_owner == 1);
        check("m_dma_rdvalid", dma_rdvalid, m_owner == 2);
        if (m_owner != 0) check("m_rddata", rddata, m_rdata);
        check("m_fill_busy", fill_busy, m_rem > 0);
        check("m_fill_done", fill_done, m_done);
    endtask

    // Cross the clock edge and advance the model by one cycle.
    task automatic half2();
        logic [11:0] a; logic [31:0] d; logic [3:0] b; logic w; bit other; bit nd;
        @(posedge clk);
        other = dma_req || (m_rem > 0);
        a = 12'h000; d = 32'h0; b = 4'h0; w = 1'b0;
        if (m_win == 1) begin a = cpu_addr; d = cpu_wrdata; b = cpu_bytesel; w = cpu_wren; end
        if (m_win == 2) begin a = dma_addr; d = dma_wrdata; b = dma_bytesel; w = dma_wren; end
        if (m_win == 3) begin a = m_faddr;  d = m_fdata;    b = 4'hF;        w = 1'b1;     end
        m_owner = 0;
        if (m_win != 0) begin
            if (w) ref_mem[a] = merge(ref_mem[a], d, b);
            else begin m_owner = m_win; m_rdata = ref_mem[a]; end
        end
        if (m_win >= 2) begin m_starve = 0; m_rr = !m_rr; end
        else if (other) m_starve++;
        nd = 1'b0;
        if (m_win == 3) begin
            m_faddr = m_faddr + 12'd1;
            m_rem--;
            if (m_rem == 0) nd = 1'b1;
        end else if (m_rem == 0 && !m_done && fill_start) begin
            m_faddr = fill_addr;
            m_fdata = fill_data;
            if (fill_len == 13'd0) nd = 1'b1;
            else m_rem = int'(fill_len);
        end
        m_done = nd;
        #2;
    endtask

    task automatic tick();
        half1();
        half2();
    endtask

    task automatic idle_inputs();
        cpu_req = 1'b0; cpu_wren = 1'b0; cpu_addr = 12'h000; cpu_wrdata = 32'h0; cpu_bytesel = 4'hF;
        dma_req = 1'b0; dma_wren = 1'b0; dma_addr = 12'h000; dma_wrdata = 32'h0; dma_bytesel = 4'hF;
        fill_start = 1'b0; fill_addr = 12'h000; fill_len = 13'd0; fill_data = 32'h0;
    endtask

    // Pulse reset for one cycle; entered and left at posedge+2.
    task automatic reset_dut();
        reset_n = 1'b0;
        model_reset();
        @(posedge clk);
        #2;
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic cr; logic cw; logic [11:0] ca; logic [31:0] cd;
        logic fs; logic [11:0] fa; logic [12:0] fl; logic [31:0] fd;
        logic e_cack; logic e_wren; logic [11:0] e_addr; logic [31:0] e_wdata;
        logic e_crdv; logic [31:0] e_rd; logic e_busy; logic e_done;
    } vec_t;

    vec_t tbl [12];

    initial begin
        int  cnt;
        int  who;
        bit  cpu_hold, dma_hold;

        tbl[0]  = '{1'b1, 1'b1, 12'h123, 32'hDEADBEEF, 1'b0, 12'h000, 13'd0, 32'h0,
                    1'b1, 1'b1, 12'h123, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 12'h123, 32'h0, 1'b0, 12'h000, 13'd0, 32'h0,
                    1'b1, 1'b0, 12'h123, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 12'h000, 13'd0, 32'h0,
                    1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 12'hFFE, 13'd4, 32'h55AA55AA,
                    1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 12'h000, 13'd0, 32'h0,
                    1'b0, 1'b1, 12'hFFE, 32'h55AA55AA, 1'b0, 32'h0, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 12'h000, 13'd0, 32'h0,
                    1'b0, 1'b1, 12'hFFF, 32'h55AA55AA, 1'b0, 32'h0, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 12'h000, 13'd0, 32'h0,
                    1'b0, 1'b1, 12'h000, 32'h55AA55AA, 1'b0, 32'h0, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 12'h000, 13'd0, 32'h0,
                    1'b0, 1'b1, 12'h001, 32'h55AA55AA, 1'b0, 32'h0, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 12'h000, 13'd0, 32'h0,
                    1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 12'h0AB, 13'd0, 32'h00000001,
                    1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 12'h000, 13'd0, 32'h0,
                    1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 12'h000, 13'd0, 32'h0,
                    1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0};

        // ---- reset state, with a CPU request present while reset is held ----
        idle_inputs();
        reset_n = 1'b1;
        model_reset();
        #1 reset_n = 1'b0;
        cpu_req = 1'b1; cpu_wren = 1'b1; cpu_addr = 12'h055; cpu_wrdata = 32'h1111_2222;
        repeat (2) @(posedge clk);
        #2;
        check("rst_cpu_ack", cpu_ack, 1'b0);
        check("rst_dma_ack", dma_ack, 1'b0);
        check("rst_cpu_rdvalid", cpu_rdvalid, 1'b0);
        check("rst_dma_rdvalid", dma_rdvalid, 1'b0);
        check("rst_fill_busy", fill_busy, 1'b0);
        check("rst_fill_done", fill_done, 1'b0);
        check("rst_vram_wren", vram_wren, 1'b0);
        check("rst_vram_addr", vram_addr, 12'h000);
        check("rst_vram_wrdata", vram_wrdata, 32'h0);
        idle_inputs();
        reset_n = 1'b1;

        // ---- full-size fill (4096 words) also initialises both memories ----
        fill_start = 1'b1; fill_addr = 12'h000; fill_len = 13'h1000; fill_data = 32'h0BAD_F00D;
        tick();
        idle_inputs();
        cnt = 0;
        for (int i = 0; i < 4200 && (m_rem > 0 || m_done); i++) begin
            half1();
            if (vram_wren) cnt++;
            half2();
        end
        check("full_fill_words", cnt, 4096);
        check("full_fill_finished", (m_rem == 0 && !m_done), 1'b1);

        // ---- directed table: CPU write/read, wrapping fill, zero-length fill ----
        reset_dut();
        for (int i = 0; i < 12; i++) begin
            idle_inputs();
            cpu_req = tbl[i].cr; cpu_wren = tbl[i].cw; cpu_addr = tbl[i].ca; cpu_wrdata = tbl[i].cd;
            fill_start = tbl[i].fs; fill_addr = tbl[i].fa; fill_len = tbl[i].fl; fill_data = tbl[i].fd;
            half1();
            check($sformatf("tbl%0d_cpu_ack", i), cpu_ack, tbl[i].e_cack);
            check($sformatf("tbl%0d_vram_wren", i), vram_wren, tbl[i].e_wren);
            check($sformatf("tbl%0d_vram_addr", i), vram_addr, tbl[i].e_addr);
            check($sformatf("tbl%0d_vram_wrdata", i), vram_wrdata, tbl[i].e_wdata);
            check($sformatf("tbl%0d_cpu_rdvalid", i), cpu_rdvalid, tbl[i].e_crdv);
            if (tbl[i].e_crdv) check($sformatf("tbl%0d_rddata", i), rddata, tbl[i].e_rd);
            check($sformatf("tbl%0d_fill_busy", i), fill_busy, tbl[i].e_busy);
            check($sformatf("tbl%0d_fill_done", i), fill_done, tbl[i].e_done);
            half2();
        end

        // ---- starvation: CPU held, DMA waiting -> DMA wins on the 9th cycle ----
        reset_dut();
        for (int i = 1; i <= 10; i++) begin
            idle_inputs();
            cpu_req = 1'b1; cpu_wren = 1'b1; cpu_addr = 12'h010 + 12'(i); cpu_wrdata = 32'(i);
            dma_req = (i <= 9); dma_wren = 1'b1; dma_addr = 12'h020; dma_wrdata = 32'hD0D0_D0D0;
            half1();
            check($sformatf("starve%0d_cpu_ack", i), cpu_ack, i != 9);
            check($sformatf("starve%0d_dma_ack", i), dma_ack, i == 9);
            half2();
        end

        // ---- DMA/fill alternation; a second fill_start while busy is ignored ----
        reset_dut();
        for (int i = 1; i <= 10; i++) begin
            idle_inputs();
            dma_req = 1'b1; dma_wren = 1'b1; dma_addr = 12'h030 + 12'(i); dma_wrdata = 32'(i);
            if (i == 1) begin fill_start = 1'b1; fill_addr = 12'h200; fill_len = 13'd4; fill_data = 32'hF111_F111; end
            if (i == 3) begin fill_start = 1'b1; fill_addr = 12'h400; fill_len = 13'd9; fill_data = 32'hBAD0_BAD0; end
            half1();
            who = dma_ack ? 2 : ((vram_wren && !cpu_ack) ? 3 : 0);
            check($sformatf("rr%0d_grant", i), who, (i <= 8 && (i % 2) == 0) ? 3 : 2);
            check($sformatf("rr%0d_fill_done", i), fill_done, i == 9);
            half2();
        end

        // ---- reset during a fill after 2 of 10 words ----
        reset_dut();
        idle_inputs();
        fill_start = 1'b1; fill_addr = 12'h300; fill_len = 13'd10; fill_data = 32'h1234_5678;
        tick();
        idle_inputs();
        tick();
        tick();
        reset_n = 1'b0;
        model_reset();
        #1;
        check("midrst_fill_busy", fill_busy, 1'b0);
        check("midrst_fill_done", fill_done, 1'b0);
        check("midrst_vram_wren", vram_wren, 1'b0);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            half1();
            if (fill_done) cnt++;
            half2();
        end
        check("midrst_no_done", cnt, 0);
        fill_start = 1'b1; fill_addr = 12'hFFF; fill_len = 13'd2; fill_data = 32'hCAFE_0001;
        tick();
        idle_inputs();
        repeat (4) tick();

        // ---- randomized traffic against the model ----
        cpu_hold = 1'b0;
        dma_hold = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (!cpu_hold) begin
                cpu_req = ($urandom_range(0, 2) == 0);
                cpu_wren = 1'($urandom_range(0, 1));
                cpu_addr = 12'($urandom_range(0, 15)) + (($urandom_range(0, 1) == 1) ? 12'hFF0 : 12'h000);
                cpu_wrdata = $urandom;
                cpu_bytesel = 4'($urandom_range(1, 15));
            end
            if (!dma_hold) begin
                dma_req = ($urandom_range(0, 1) == 0);
                dma_wren = 1'($urandom_range(0, 1));
                dma_addr = 12'($urandom_range(0, 15)) + (($urandom_range(0, 1) == 1) ? 12'hFF0 : 12'h000);
                dma_wrdata = $urandom;
                dma_bytesel = 4'($urandom_range(1, 15));
            end
            fill_start = ($urandom_range(0, 29) == 0);
            fill_addr = 12'($urandom_range(4088, 4095));
            fill_len = 13'($urandom_range(0, 8));
            fill_data = $urandom;
            tick();
            cpu_hold = cpu_req && (m_win != 1);
            dma_hold = dma_req && (m_win != 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vram_port_arbiter.md
Name: vram_port_arbiter

Overview:
- Shares the single 32-bit CPU-side port of the dual-port VRAM between three requesters: CPU bus, DMA engine, and a built-in fill engine that clears or fills VRAM with a word pattern.
- Sits between the bus interconnect/DMA and the VRAM CPU port.
- The video port of the VRAM is untouched.
- Provides the request/ack handshake, read-data return, starvation protection, and the fill sequencer.

Parameters:
ADDR_W, 12, VRAM word address width (4096 x 32-bit words)
STARVE_MAX, 8, consecutive denied cycles after which a waiting DMA/fill request overrides the CPU

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
cpu_req  input  1  CPU access request, held until cpu_ack
cpu_addr  input  ADDR_W  CPU word address
cpu_wrdata  input  32  CPU write data
cpu_bytesel  input  4  CPU byte enables
cpu_wren  input  1  1=write, 0=read
cpu_ack  output  1  CPU request accepted this cycle
cpu_rdvalid  output  1  CPU read data valid
dma_req  input  1  DMA access request, held until dma_ack
dma_addr  input  ADDR_W  DMA word address
dma_wrdata  input  32  DMA write data
dma_bytesel  input  4  DMA byte enables
dma_wren  input  1  1=write, 0=read
dma_ack  output  1  DMA request accepted this cycle
dma_rdvalid  output  1  DMA read data valid
rddata  output  32  read data, shared; qualify with *_rdvalid
fill_start  input  1  one-cycle pulse, start fill
fill_addr  input  ADDR_W  fill start word address
fill_len  input  ADDR_W+1  number of words to fill (0..4096)
fill_data  input  32  fill pattern, sampled at fill_start
fill_busy  output  1  fill in progress
fill_done  output  1  one-cycle pulse at fill completion
vram_addr  output  ADDR_W  to VRAM port 1 address
vram_wrdata  output  32  to VRAM port 1 write data
vram_bytesel  output  4  to VRAM port 1 byte enables
vram_wren  output  1  to VRAM port 1 write enable
vram_rddata  input  32  from VRAM port 1; valid one clk after the address is presented

Behaviour:
- Reset (async, reset_n=0) clears all acks, rdvalids, fill_busy, fill_done, starvation counters, and round-robin pointer to 0. vram_* outputs are 0.
- Grant is combinational from the current requests and registered state. At most one grant per cycle. A granted requester's ack is high in the same cycle; the VRAM samples on the following clk edge.
- Priority:
  - CPU wins by default.
  - DMA and fill alternate by round-robin pointer. The pointer toggles after each DMA or fill grant.
  - If the starvation counter reaches STARVE_MAX, the non-CPU side beats the CPU for one grant. The counter counts cycles where a DMA/fill request was pending and not granted. It is cleared on any DMA/fill grant.
- vram_* outputs carry the granted requester's fields. With no grant: vram_wren=0, and addr/wrdata/bytesel=0.
- Read return: *_rdvalid is asserted exactly one cycle after an ack with wren=0. rddata = vram_rddata in that cycle. Writes produce no rdvalid.
- Fill FSM states:
  - IDLE: fill_start latches addr, len, and data.
    - len=0: go to DONE.
    - Otherwise go to RUN with fill_busy=1.
  - RUN: issues full-word writes (bytesel=4'hF) as the fill requester. On each grant, the address increments modulo 2^ADDR_W (wraps 4095->0) and the remaining count decrements. The grant of the last word goes to DONE.
  - DONE: fill_done=1 for one cycle, fill_busy=0, then IDLE.
  - fill_start while busy or in DONE is ignored.
- Simultaneous events:
  - A CPU request arriving in the same cycle the fill ends is served normally.
  - A DMA read and a CPU read on consecutive cycles return data on consecutive cycles, each flagged by its own rdvalid.
- Reset mid-fill aborts immediately. No fill_done pulse. Partially written VRAM contents are left as they are.

Test Plan:
- Reset, then CPU write addr 0x123 data 0xDEADBEEF bytesel 0xF, then CPU read 0x123 -> cpu_ack same cycle as each request; cpu_rdvalid one cycle after the read ack with rddata=0xDEADBEEF.
- fill_addr=0xFFE, len=4, data=0x55AA55AA, no other traffic -> writes to 0xFFE,0xFFF,0x000,0x001 on 4 consecutive cycles; fill_done pulse next cycle; fill_busy low after.
- CPU req held continuously with dma_req pending, STARVE_MAX=8 -> DMA granted on 9th cycle; CPU re-granted the cycle after; counter resets.
- dma_req and fill both pending, no CPU -> grants alternate DMA, fill, DMA, fill; no two consecutive grants to the same requester.
- fill_len=0 -> fill_done one cycle after fill_start; no vram_wren; fill_busy never asserted. fill_start during busy -> ignored; original count completes.
- reset_n low during RUN after 2 of 10 words -> fill_busy=0 immediately; no fill_done; subsequent fill_start works normally.
